// File: rtl/sdr_pkg.sv
// Constants shared between the SDR SDRAM command FSM and its read-data return path.
package sdr_pkg;
  localparam int SDR_CL2 = 2;
  localparam int SDR_CL3 = 3;
  localparam int SDR_BL2 = 2;
  // Burst-length field value written into the mode register for BL=2.
  localparam logic [2:0] SDR_BL2_ENC = 3'b001;

  typedef logic [1:0] pend_cnt_t;
  localparam pend_cnt_t PEND_MAX = 2'd3;
endpackage

// File: rtl/sdr_dly_line.sv
// Single-bit shift register; taps[k] is the input delayed by k+1 clocks.
module sdr_dly_line #(
  parameter int DEPTH = 4
) (
  input  logic             sdram_clk,
  input  logic             sdram_rst_n,
  input  logic             din,
  output logic [DEPTH-1:0] taps
);

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) taps <= '0;
    else              taps <= {taps[DEPTH-2:0], din};
  end

endmodule

// File: rtl/sdr_16_rd_capture.sv
// SDR SDRAM read-return path: tracks RD commands through CAS latency, packs the two
// 16-bit beats of each burst into one 32-bit word and pushes it into the egress FIFO.
import sdr_pkg::*;

module sdr_16_rd_capture #(
  parameter int cl     = 2,
  parameter int rd_dly = 1
) (
  input  logic        sdram_clk,
  input  logic        sdram_rst_n,
  input  logic        cmd_read,
  input  logic [15:0] dq_i,
  input  logic        fifo_full,
  output logic        fifo_we,
  output logic [31:0] fifo_dat,
  output logic        rd_pending,
  input  logic        err_clr,
  output logic        overrun,
  output logic        proto_err
);

  localparam int L      = cl + rd_dly;
  localparam int PIPE_D = L + SDR_BL2 - 1;

  function automatic pend_cnt_t pend_step(input pend_cnt_t c, input logic inc, input logic dec);
    if (inc && !dec) return (c == PEND_MAX) ? c : c + 2'd1;
    if (dec && !inc) return (c == '0) ? c : c - 2'd1;
    return c;
  endfunction

  logic              cmd_read_p0;
  logic              accept;
  logic [PIPE_D-1:0] pipe;
  logic              cap_hi;
  logic              formed;
  logic              push;
  logic              drop;
  logic              sat_ev;
  logic              proto_ev;
  logic [15:0]       hi_p1;
  pend_cnt_t         cnt;
  logic              vld_p2;

  // A pulse directly following another is a protocol error and never enters the pipe.
  assign accept   = cmd_read & ~cmd_read_p0;
  assign cap_hi   = pipe[L-1];
  assign formed   = pipe[L];
  assign push     = formed & ~fifo_full;
  assign drop     = formed & fifo_full;
  assign sat_ev   = accept & ~formed & (cnt == PEND_MAX);
  assign proto_ev = (cmd_read & cmd_read_p0) | sat_ev;

  sdr_dly_line #(.DEPTH(PIPE_D)) u_cmd_dly (
    .sdram_clk   (sdram_clk),
    .sdram_rst_n (sdram_rst_n),
    .din         (accept),
    .taps        (pipe)
  );

  // Stage p1: beat0 held until beat1 arrives
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n)  hi_p1 <= '0;
    else if (cap_hi)   hi_p1 <= dq_i;
  end

  // Stage p2: packed word registered toward the FIFO
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) fifo_dat <= '0;
    else if (push)    fifo_dat <= {hi_p1, dq_i};
  end

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      cmd_read_p0 <= 1'b0;
      cnt         <= '0;
      vld_p2      <= 1'b0;
      fifo_we     <= 1'b0;
      overrun     <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      cmd_read_p0 <= cmd_read;
      cnt         <= pend_step(cnt, accept, formed);
      vld_p2      <= formed;
      fifo_we     <= push;
      if (drop)         overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
      if (proto_ev)     proto_err <= 1'b1;
      else if (err_clr) proto_err <= 1'b0;
    end
  end

  // The output stage counts as pending so the flag covers the push cycle itself.
  assign rd_pending = (cnt != '0) | (|pipe) | vld_p2;

endmodule

// File: tb/tb_sdr_16_rd_capture.sv
// Bench for sdr_16_rd_capture: two instances (L=3 and L=4) against a history-based model.
module tb_sdr_16_rd_capture;

  localparam int N = 8192;

  logic        sdram_clk;
  logic        sdram_rst_n;
  logic        cmd_read;
  logic [15:0] dq_i;
  logic        fifo_full;
  logic        err_clr;

  logic        we_a, pend_a, ovr_a, pe_a;
  logic [31:0] dat_a;
  logic        we_b, pend_b, ovr_b, pe_b;
  logic [31:0] dat_b;

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  bit          cmd_h  [N];
  logic [15:0] dq_h   [N];
  bit          full_h [N];
  bit          clr_h  [N];
  bit          rst_h  [N];

  logic        we_h   [2][N];
  logic [31:0] dat_h  [2][N];
  logic        pend_h [2][N];
  logic        ovr_h  [2][N];
  logic        pe_h   [2][N];

  logic [31:0] m_dat [2];
  bit          m_ovr [2];
  bit          m_pe  [2];

  sdr_16_rd_capture #(.cl(2), .rd_dly(1)) dut_a (
    .sdram_clk(sdram_clk), .sdram_rst_n(sdram_rst_n), .cmd_read(cmd_read), .dq_i(dq_i),
    .fifo_full(fifo_full), .fifo_we(we_a), .fifo_dat(dat_a), .rd_pending(pend_a),
    .err_clr(err_clr), .overrun(ovr_a), .proto_err(pe_a)
  );

  sdr_16_rd_capture #(.cl(3), .rd_dly(1)) dut_b (
    .sdram_clk(sdram_clk), .sdram_rst_n(sdram_rst_n), .cmd_read(cmd_read), .dq_i(dq_i),
    .fifo_full(fifo_full), .fifo_we(we_b), .fifo_dat(dat_b), .rd_pending(pend_b),
    .err_clr(err_clr), .overrun(ovr_b), .proto_err(pe_b)
  );

  initial begin
    sdram_clk = 1'b0;
    forever #5 sdram_clk = ~sdram_clk;
  end

  task automatic chk(input string name, input int dut, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s dut%0d cyc %0d got %h expected %h", name, dut, cyc, got, exp);
  endtask

  // A read issued in cycle t is accepted unless a pulse was also accepted-or-not in t-1.
  function automatic bit acc(input int t);
    if (t < 1) return 1'b0;
    return cmd_h[t] && !rst_h[t] && !(cmd_h[t-1] && !rst_h[t-1]);
  endfunction

  function automatic bit alive(input int t, input int c);
    for (int r = t; r <= c; r++) if (rst_h[r]) return 1'b0;
    return 1'b1;
  endfunction

  // Per-cycle model and compare, sampled on the falling edge.
  initial begin
    int c, L, t;
    bit e_we, e_pend, drop, pe_ev;
    for (int k = 0; k < 2; k++) begin
      m_dat[k] = '0; m_ovr[k] = 1'b0; m_pe[k] = 1'b0;
    end
    forever begin
      @(negedge sdram_clk);
      c = cyc;
      cmd_h[c]  = cmd_read;
      dq_h[c]   = dq_i;
      full_h[c] = fifo_full;
      clr_h[c]  = err_clr;
      rst_h[c]  = !sdram_rst_n;
      we_h[0][c] = we_a; dat_h[0][c] = dat_a; pend_h[0][c] = pend_a; ovr_h[0][c] = ovr_a; pe_h[0][c] = pe_a;
      we_h[1][c] = we_b; dat_h[1][c] = dat_b; pend_h[1][c] = pend_b; ovr_h[1][c] = ovr_b; pe_h[1][c] = pe_b;
      if (c >= 2) begin
        for (int k = 0; k < 2; k++) begin
          L = (k == 0) ? 3 : 4;
          e_we = 1'b0; e_pend = 1'b0;
          if (rst_h[c]) begin
            m_dat[k] = '0; m_ovr[k] = 1'b0; m_pe[k] = 1'b0;
          end else begin
            t     = c - L - 2;
            e_we  = acc(t) && alive(t, c) && !full_h[c-1];
            drop  = acc(t) && alive(t, c) && full_h[c-1];
            pe_ev = cmd_h[c-1] && !rst_h[c-1] && cmd_h[c-2] && !rst_h[c-2];
            if (e_we) m_dat[k] = {dq_h[t+L], dq_h[t+L+1]};
            if (drop) m_ovr[k] = 1'b1;
            else if (clr_h[c-1]) m_ovr[k] = 1'b0;
            if (pe_ev) m_pe[k] = 1'b1;
            else if (clr_h[c-1]) m_pe[k] = 1'b0;
            for (int tt = c - L - 2; tt <= c - 1; tt++)
              if (acc(tt) && alive(tt, c)) e_pend = 1'b1;
          end
          chk("fifo_we",    k, 32'(we_h[k][c]),   32'(e_we));
          chk("fifo_dat",   k, dat_h[k][c],       m_dat[k]);
          chk("rd_pending", k, 32'(pend_h[k][c]), 32'(e_pend));
          chk("overrun",    k, 32'(ovr_h[k][c]),  32'(m_ovr[k]));
          chk("proto_err",  k, 32'(pe_h[k][c]),   32'(m_pe[k]));
        end
      end
    end
  end

  task automatic drive(input bit c, input logic [15:0] d, input bit f, input bit e, input bit r);
    @(posedge sdram_clk);
    #1;
    cyc         = cyc + 1;
    cmd_read    = c;
    dq_i        = d;
    fifo_full   = f;
    err_clr     = e;
    sdram_rst_n = !r;
  endtask

  function automatic int pushes(input int k, input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) n += int'(we_h[k][c]);
    return n;
  endfunction

  initial begin
    int b;
    logic [15:0] d;
    sdram_rst_n = 1'b1; cmd_read = 1'b0; dq_i = '0; fifo_full = 1'b0; err_clr = 1'b0;
    #1 sdram_rst_n = 1'b0;
    repeat (4) drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    repeat (2) drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_we",   0, 32'(we_h[0][3]),   32'd0);
    chk("rst_dat",  1, dat_h[1][3],       32'h0);
    chk("rst_pend", 1, 32'(pend_h[1][3]), 32'd0);

    // Test 1: single read, L=3 instance
    b = cyc + 1;
    for (int i = 0; i < 40; i++) begin
      d = (i == 13) ? 16'hA5A5 : (i == 14) ? 16'h3C3C : 16'($urandom);
      drive(i == 10, d, 1'b0, 1'b0, 1'b0);
    end
    chk("t1_we15",  0, 32'(we_h[0][b+15]), 32'd1);
    chk("t1_dat15", 0, dat_h[0][b+15],     32'hA5A5_3C3C);
    chk("t1_pushes",0, pushes(0, b, b+30), 32'd1);

    // Test 2: back-to-back reads every second cycle, L=4 instance
    b = cyc + 1;
    for (int i = 0; i < 40; i++) begin
      d = (i >= 14 && i <= 21) ? 16'(i - 13) : 16'h0;
      drive(i == 10 || i == 12 || i == 14 || i == 16, d, 1'b0, 1'b0, 1'b0);
    end
    chk("t2_dat16", 1, dat_h[1][b+16], 32'h0001_0002);
    chk("t2_dat18", 1, dat_h[1][b+18], 32'h0003_0004);
    chk("t2_dat20", 1, dat_h[1][b+20], 32'h0005_0006);
    chk("t2_dat22", 1, dat_h[1][b+22], 32'h0007_0008);
    chk("t2_we17",  1, 32'(we_h[1][b+17]),   32'd0);
    chk("t2_pushes",1, pushes(1, b, b+30),   32'd4);
    chk("t2_pend10",1, 32'(pend_h[1][b+10]), 32'd0);
    chk("t2_pend11",1, 32'(pend_h[1][b+11]), 32'd1);
    chk("t2_pend22",1, 32'(pend_h[1][b+22]), 32'd1);
    chk("t2_pend23",1, 32'(pend_h[1][b+23]), 32'd0);

    // Test 3: second word dropped on fifo_full, then flag cleared
    b = cyc + 1;
    for (int i = 0; i < 40; i++) begin
      d = (i >= 14 && i <= 21) ? 16'(i - 13) : 16'h0;
      drive(i == 10 || i == 12 || i == 14 || i == 16, d, i == 17, i == 25, 1'b0);
    end
    chk("t3_pushes", 1, pushes(1, b, b+30),  32'd3);
    chk("t3_ovr17",  1, 32'(ovr_h[1][b+17]), 32'd0);
    chk("t3_ovr18",  1, 32'(ovr_h[1][b+18]), 32'd1);
    chk("t3_ovr26",  1, 32'(ovr_h[1][b+26]), 32'd0);

    // Test 4: two adjacent pulses
    b = cyc + 1;
    for (int i = 0; i < 40; i++)
      drive(i == 10 || i == 11, 16'(16'h0100 + i), 1'b0, i == 30, 1'b0);
    chk("t4_pe11",   1, 32'(pe_h[1][b+11]),  32'd0);
    chk("t4_pe12",   1, 32'(pe_h[1][b+12]),  32'd1);
    chk("t4_pushes", 1, pushes(1, b, b+29),  32'd1);
    chk("t4_pe31",   1, 32'(pe_h[1][b+31]),  32'd0);

    // Test 5: reset in the first-beat cycle
    b = cyc + 1;
    for (int i = 0; i < 40; i++)
      drive(i == 10, 16'($urandom), 1'b0, 1'b0, i == 14);
    chk("t5_pend13", 1, 32'(pend_h[1][b+13]), 32'd1);
    chk("t5_pushes", 1, pushes(1, b+14, b+30), 32'd0);
    chk("t5_dat15",  1, dat_h[1][b+15],       32'h0);
    chk("t5_pend15", 1, 32'(pend_h[1][b+15]), 32'd0);

    // Test 6: drop and err_clr in the same cycle
    b = cyc + 1;
    for (int i = 0; i < 40; i++)
      drive(i == 10, 16'($urandom), i == 15, i == 15, 1'b0);
    chk("t6_ovr15", 1, 32'(ovr_h[1][b+15]), 32'd0);
    chk("t6_ovr16", 1, 32'(ovr_h[1][b+16]), 32'd1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 2) == 0, 16'($urandom), $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
    repeat (12) drive(1'b0, 16'($urandom), 1'b0, 1'b0, 1'b0);
    @(negedge sdram_clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
